// File: rtl/limb_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : limb_mult_seq
// Brief    : Sequential unsigned W x W multiplier issuing one 17x17 limb
//            product per cycle into a single multiplier, shift-accumulated
//            into an N*34-bit result. Optional square schedule when the
//            macro LIMB_MULT_SQUARE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module limb_mult_seq #(
  parameter int W         = 68,
  parameter int MULT_PIPE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           square,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int C_LW = 17;
  localparam int C_N  = (W + C_LW - 1) / C_LW;
  localparam int C_PW = C_N * C_LW;
  localparam int C_AW = C_N * 2 * C_LW;
  localparam int C_IW = (C_N > 1) ? $clog2(C_N) : 1;
  localparam int C_TW = (C_N > 1) ? $clog2(2 * C_N - 1) : 1;
  localparam int C_DW = $clog2(MULT_PIPE + 1) + 1;
  localparam int C_L  = MULT_PIPE - 1;
  localparam logic [C_IW-1:0] C_LAST = C_IW'(C_N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [C_PW-1:0]   r_x;
  logic [C_PW-1:0]   r_y;
  logic              r_sq;
  logic [C_IW-1:0]   r_i;
  logic [C_IW-1:0]   r_j;
  logic [C_DW-1:0]   r_drain;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic              w_accept;
  logic              w_last_pair;
  logic              w_sq_in;

`ifdef LIMB_MULT_SQUARE_EN
  assign w_sq_in = square;
`else
  logic w_unused_square;
  assign w_unused_square = square;
  assign w_sq_in         = 1'b0;
`endif

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_last_pair = (r_i == C_LAST) && (r_j == C_LAST);

  // Control FSM; all handshake outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_sq        <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_drain     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x        <= C_PW'(x);
            r_y        <= C_PW'(y);
            r_sq       <= w_sq_in;
            r_i        <= '0;
            r_j        <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_last_pair) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end else if (r_j == C_LAST) begin
            // Square schedule restarts the inner loop on the diagonal.
            r_i <= r_i + C_IW'(1);
            r_j <= r_sq ? (r_i + C_IW'(1)) : '0;
          end else begin
            r_j <= r_j + C_IW'(1);
          end
        end
        S_DRAIN: begin
          // Covers the issue register plus the MULT_PIPE multiplier stages.
          if (r_drain == C_DW'(MULT_PIPE)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_drain <= r_drain + C_DW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  logic [C_LW-1:0] w_a;
  logic [C_LW-1:0] w_b;
  logic [C_LW-1:0] r_a;
  logic [C_LW-1:0] r_b;
  logic [C_TW-1:0] r_itag;
  logic            r_idbl;
  logic            r_iv;

  assign w_a = r_x[C_LW*r_i +: C_LW];
  assign w_b = r_sq ? r_x[C_LW*r_j +: C_LW] : r_y[C_LW*r_j +: C_LW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iv   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_itag <= '0;
      r_idbl <= 1'b0;
    end else begin
      r_iv   <= (r_state == S_RUN);
      r_a    <= w_a;
      r_b    <= w_b;
      r_itag <= C_TW'(r_i) + C_TW'(r_j);
      r_idbl <= r_sq && (r_i != r_j);
    end
  end

  logic [2*C_LW-1:0] r_prod [MULT_PIPE];
  logic [C_TW-1:0]   r_ptag [MULT_PIPE];
  logic              r_pdbl [MULT_PIPE];
  logic              r_pv   [MULT_PIPE];

  // Limb multiplier: product formed into stage 0, then delayed to depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MULT_PIPE; k++) begin
        r_prod[k] <= '0;
        r_ptag[k] <= '0;
        r_pdbl[k] <= 1'b0;
        r_pv[k]   <= 1'b0;
      end
    end else begin
      r_prod[0] <= (2*C_LW)'(r_a) * (2*C_LW)'(r_b);
      r_ptag[0] <= r_itag;
      r_pdbl[0] <= r_idbl;
      r_pv[0]   <= r_iv;
      for (int k = 1; k < MULT_PIPE; k++) begin
        r_prod[k] <= r_prod[k-1];
        r_ptag[k] <= r_ptag[k-1];
        r_pdbl[k] <= r_pdbl[k-1];
        r_pv[k]   <= r_pv[k-1];
      end
    end
  end

  logic [2*C_LW:0] w_term;
  logic [C_AW-1:0] w_addend;
  logic [C_AW-1:0] r_acc;

  assign w_term   = r_pdbl[C_L] ? {r_prod[C_L], 1'b0} : {1'b0, r_prod[C_L]};
  assign w_addend = C_AW'(w_term) << (C_LW * int'(r_ptag[C_L]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (r_pv[C_L]) begin
      r_acc <= r_acc + w_addend;
    end
  end

  assign p = r_acc[2*W-1:0];

  generate
    if (C_AW > 2 * W) begin : g_acc_hi
      // Padding bits above 2W are provably zero for W-bit operands.
      logic w_unused_acc_hi;
      assign w_unused_acc_hi = |r_acc[C_AW-1:2*W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_limb_mult_seq.sv
`default_nettype none
// Bench for limb_mult_seq: three instances (68/2, 40/1, 17/1) against a
// plain-arithmetic product and latency model.
module tb_limb_mult_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [67:0]  x;
  logic [67:0]  y;
  logic         square;
  logic [2:0]   in_valid;
  logic [2:0]   out_ready;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   busy;
  logic [135:0] p68;
  logic [79:0]  p40;
  logic [33:0]  p17;
  logic [135:0] pv [3];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign pv[0] = p68;
  assign pv[1] = 136'(p40);
  assign pv[2] = 136'(p17);

  limb_mult_seq #(.W(68), .MULT_PIPE(2)) u_dut68 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .x(x), .y(y), .square(square), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .p(p68), .busy(busy[0]));

  limb_mult_seq #(.W(40), .MULT_PIPE(1)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .x(x[39:0]), .y(y[39:0]), .square(square), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .p(p40), .busy(busy[1]));

  limb_mult_seq #(.W(17), .MULT_PIPE(1)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .x(x[16:0]), .y(y[16:0]), .square(square), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .p(p17), .busy(busy[2]));

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  function automatic int width_of(input int w);
    case (w)
      0:       return 68;
      1:       return 40;
      default: return 17;
    endcase
  endfunction

  function automatic int pipe_of(input int w);
    return (w == 0) ? 2 : 1;
  endfunction

  function automatic bit sq_used(input logic sq);
`ifdef LIMB_MULT_SQUARE_EN
    return sq;
`else
    return (sq & 1'b0);
`endif
  endfunction

  function automatic logic [135:0] ref_p(input int wd, input logic [67:0] xv,
                                         input logic [67:0] yv, input logic sq);
    logic [135:0] m;
    logic [135:0] xm;
    logic [135:0] ym;
    m  = (136'd1 << wd) - 136'd1;
    xm = {68'd0, xv} & m;
    ym = sq_used(sq) ? xm : ({68'd0, yv} & m);
    return xm * ym;
  endfunction

  function automatic int ref_lat(input int w, input logic sq);
    int n;
    int k;
    n = (width_of(w) + 16) / 17;
    k = sq_used(sq) ? n * (n + 1) / 2 : n * n;
    return k + pipe_of(w) + 1;
  endfunction

  function automatic logic [67:0] rand68();
    return 68'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One full transaction: accept, latency, result, optional backpressure window.
  task automatic run_op(input int w, input logic [67:0] xv, input logic [67:0] yv,
                        input logic sq, input int hold, input bit pulse);
    logic [135:0] exp;
    int           lat;
    int           c;
    exp = ref_p(width_of(w), xv, yv, sq);
    lat = ref_lat(w, sq);
    chk("idle_in_ready", 136'(in_ready[w]), 136'd1);
    x            = xv;
    y            = yv;
    square       = sq;
    out_ready[w] = (hold == 0);
    in_valid[w]  = 1'b1;
    @(posedge clk); #1;
    in_valid[w] = 1'b0;
    x           = rand68();
    y           = rand68();
    square      = ~sq;
    chk("accept_in_ready", 136'(in_ready[w]), 136'd0);
    chk("accept_busy", 136'(busy[w]), 136'd1);
    c = 0;
    while (!out_valid[w] && c < 80) begin
      @(posedge clk); #1;
      c++;
    end
    chk("latency", 136'(c), 136'(lat));
    chk("product", pv[w], exp);
    chk("done_busy", 136'(busy[w]), 136'd1);
    for (int h = 0; h < hold; h++) begin
      if (pulse) in_valid[w] = 1'b1;
      @(posedge clk); #1;
      chk("hold_p", pv[w], exp);
      chk("hold_valid", 136'(out_valid[w]), 136'd1);
      chk("hold_busy", 136'(busy[w]), 136'd1);
      chk("hold_in_ready", 136'(in_ready[w]), 136'd0);
    end
    in_valid[w]  = 1'b0;
    out_ready[w] = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid", 136'(out_valid[w]), 136'd0);
    chk("hs_in_ready", 136'(in_ready[w]), 136'd1);
    chk("hs_busy", 136'(busy[w]), 136'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [67:0] ones;
    bit          seen;
    ones      = '1;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    x         = '0;
    y         = '0;
    square    = 1'b0;
    #12;
    for (int w = 0; w < 3; w++) begin
      chk("rst_in_ready", 136'(in_ready[w]), 136'd1);
      chk("rst_valid", 136'(out_valid[w]), 136'd0);
      chk("rst_busy", 136'(busy[w]), 136'd0);
      chk("rst_p", pv[w], 136'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, ones, ones, 1'b0, 0, 1'b0);
    chk("all_ones_const", p68, ({68'd0, ones} * {68'd0, ones}));
    run_op(0, 68'h1_2345_6789_ABCD_EF01, 68'd0, 1'b0, 0, 1'b0);
    run_op(0, 68'h1_2345_6789_ABCD_EF01, 68'd1, 1'b0, 0, 1'b0);
    run_op(0, ones, 68'hDEAD, 1'b1, 0, 1'b0);
    run_op(0, rand68(), rand68(), 1'b0, 5, 1'b1);

    // Abort mid-run with an asynchronous reset.
    x            = ones;
    y            = ones;
    square       = 1'b0;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 136'(in_ready[0]), 136'd1);
    chk("abort_valid", 136'(out_valid[0]), 136'd0);
    chk("abort_busy", 136'(busy[0]), 136'd0);
    chk("abort_p", p68, 136'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    chk("abort_no_valid", 136'(seen), 136'd0);
    run_op(0, 68'd3, 68'd5, 1'b0, 0, 1'b0);

    for (int w = 0; w < 3; w++) begin
      repeat (6) begin
        run_op(w, rand68(), rand68(), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
    end
    run_op(1, ones, ones, 1'b0, 0, 1'b0);
    run_op(2, ones, ones, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
